// File: rtl/draw_obstacle.sv
// draw_obstacle: overlays up to two vertically stacked obstacles on a video
// stream. Obstacle geometry and the endgame flag are sampled once per frame
// so that a frame is always drawn from one consistent snapshot. In endgame
// the obstacles turn red and blink with a half-period of BLINK_FRAMES frames.
// Two-stage pipeline: stage 1 registers timing, colour and hit flag; stage 2
// chooses the output colour.
module draw_obstacle #(
    parameter int          OBST_W       = 40,
    parameter int          OBST_H       = 30,
    parameter logic [11:0] COLOR_OK     = 12'h0F0,
    parameter logic [11:0] COLOR_END    = 12'hF00,
    parameter int          BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] obstacle_xpos_1,
    input  logic [11:0] obstacle_ypos_1,
    input  logic [11:0] obstacle_ypos_2,
    input  logic        endgame,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam int              CNT_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [12:0]     OBST_W_13 = 13'(OBST_W);
    localparam logic [12:0]     OBST_H_13 = 13'(OBST_H);

    // Frame detection and per-frame snapshot
    logic        prev_vblnk_r;
    logic        frame_start_s;
    logic [11:0] shadow_xpos_r;
    logic [11:0] shadow_ypos_1_r;
    logic [11:0] shadow_ypos_2_r;
    logic        shadow_endgame_r;

    // Blink state
    logic [CNT_W-1:0] blink_cnt_r;
    logic             blink_phase_r;
    logic             draw_en_s;

    // Hit test (13-bit so edges near 4095 clip instead of wrapping)
    logic [12:0] hc_ext_s;
    logic [12:0] vc_ext_s;
    logic [12:0] x_lo_s;
    logic [12:0] x_hi_s;
    logic [12:0] y1_lo_s;
    logic [12:0] y1_hi_s;
    logic [12:0] y2_lo_s;
    logic [12:0] y2_hi_s;
    logic        in_x_s;
    logic        in_y1_s;
    logic        in_y2_s;
    logic        in_obst_s;

    // Stage 1 registers
    logic [10:0] hcount_1_r;
    logic [10:0] vcount_1_r;
    logic        hsync_1_r;
    logic        vsync_1_r;
    logic        hblnk_1_r;
    logic        vblnk_1_r;
    logic [11:0] rgb_1_r;
    logic        in_obst_1_r;

    // Stage 2 colour choice
    logic [11:0] color_s;

    assign frame_start_s = vblnk_in & ~prev_vblnk_r;
    assign draw_en_s     = ~blink_phase_r;

    // Track previous vblnk and latch obstacle geometry at each frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_vblnk_r     <= 1'b0;
            shadow_xpos_r    <= 12'd0;
            shadow_ypos_1_r  <= 12'd0;
            shadow_ypos_2_r  <= 12'd0;
            shadow_endgame_r <= 1'b0;
        end else begin
            prev_vblnk_r <= vblnk_in;
            if (frame_start_s) begin
                shadow_xpos_r    <= obstacle_xpos_1;
                shadow_ypos_1_r  <= obstacle_ypos_1;
                shadow_ypos_2_r  <= obstacle_ypos_2;
                shadow_endgame_r <= endgame;
            end
        end
    end

    // Blink counter: parked at zero during play, steps once per endgame frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (frame_start_s) begin
            if (!endgame) begin
                // Leaving (or not in) endgame: restart from a visible phase
                blink_cnt_r   <= '0;
                blink_phase_r <= 1'b0;
            end else if (shadow_endgame_r) begin
                if (blink_cnt_r == CNT_LAST) begin
                    blink_cnt_r   <= '0;
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + CNT_W'(1'b1);
                end
            end else begin
                // First endgame frame is drawn with the counter still at zero
                blink_cnt_r   <= '0;
                blink_phase_r <= 1'b0;
            end
        end
    end

    // Hit test of the current pixel against both obstacles
    always_comb begin
        hc_ext_s  = {2'b00, hcount_in};
        vc_ext_s  = {2'b00, vcount_in};
        x_lo_s    = {1'b0, shadow_xpos_r};
        x_hi_s    = x_lo_s + OBST_W_13;
        y1_lo_s   = {1'b0, shadow_ypos_1_r};
        y1_hi_s   = y1_lo_s + OBST_H_13;
        y2_lo_s   = {1'b0, shadow_ypos_2_r};
        y2_hi_s   = y2_lo_s + OBST_H_13;
        in_x_s    = (shadow_xpos_r != 12'd0) && (hc_ext_s >= x_lo_s) && (hc_ext_s < x_hi_s);
        in_y1_s   = (vc_ext_s >= y1_lo_s) && (vc_ext_s < y1_hi_s);
        in_y2_s   = (vc_ext_s >= y2_lo_s) && (vc_ext_s < y2_hi_s);
        in_obst_s = in_x_s && (in_y1_s || in_y2_s);
    end

    // Stage 1: register timing, upstream colour and the hit flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_1_r  <= 11'd0;
            vcount_1_r  <= 11'd0;
            hsync_1_r   <= 1'b0;
            vsync_1_r   <= 1'b0;
            hblnk_1_r   <= 1'b0;
            vblnk_1_r   <= 1'b0;
            rgb_1_r     <= 12'd0;
            in_obst_1_r <= 1'b0;
        end else begin
            hcount_1_r  <= hcount_in;
            vcount_1_r  <= vcount_in;
            hsync_1_r   <= hsync_in;
            vsync_1_r   <= vsync_in;
            hblnk_1_r   <= hblnk_in;
            vblnk_1_r   <= vblnk_in;
            rgb_1_r     <= rgb_in;
            in_obst_1_r <= in_obst_s;
        end
    end

    // Stage 2 colour choice: blanking passes through, then obstacle, then background
    always_comb begin
        color_s = rgb_1_r;
        if (hblnk_1_r || vblnk_1_r) begin
            color_s = rgb_1_r;
        end else if (in_obst_1_r && draw_en_s) begin
            color_s = shadow_endgame_r ? COLOR_END : COLOR_OK;
        end else begin
            color_s = rgb_1_r;
        end
    end

    // Stage 2: register the outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= hcount_1_r;
            vcount_out <= vcount_1_r;
            hsync_out  <= hsync_1_r;
            vsync_out  <= vsync_1_r;
            hblnk_out  <= hblnk_1_r;
            vblnk_out  <= vblnk_1_r;
            rgb_out    <= color_s;
        end
    end

endmodule

// File: tb/tb_draw_obstacle.sv
// Bench for draw_obstacle: random and directed pixel streams compared against
// a frame-level reference model (snapshot per frame, blink from frame count).
module tb_draw_obstacle;

    localparam int          OBST_W       = 40;
    localparam int          OBST_H       = 30;
    localparam logic [11:0] COLOR_OK     = 12'h0F0;
    localparam logic [11:0] COLOR_END    = 12'hF00;
    localparam int          BLINK_FRAMES = 16;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [11:0] obstacle_xpos_1, obstacle_ypos_1, obstacle_ypos_2;
    logic        endgame;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [37:0] obs_s;

    // Reference model state
    int          m_x, m_y1, m_y2;
    bit          m_eg;
    int          m_end_frames;
    bit          m_prev_vb;
    logic [37:0] exp_prev;
    logic [37:0] got_v, want_v;
    pix_t        pix_q[$];

    int checks = 0;
    int errors = 0;

    draw_obstacle #(
        .OBST_W(OBST_W), .OBST_H(OBST_H), .COLOR_OK(COLOR_OK),
        .COLOR_END(COLOR_END), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .obstacle_xpos_1(obstacle_xpos_1), .obstacle_ypos_1(obstacle_ypos_1),
        .obstacle_ypos_2(obstacle_ypos_2), .endgame(endgame),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
    );

    assign obs_s = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};

    always #5 clk = ~clk;

    task automatic model_reset();
        m_x = 0; m_y1 = 0; m_y2 = 0; m_eg = 1'b0;
        m_end_frames = 0; m_prev_vb = 1'b0;
        exp_prev = 38'd0;
    endtask

    // Drive one pixel, predict its output, sample what the previous pixel produced
    task automatic step(input pix_t p);
        logic [11:0] want_rgb;
        logic        hs, vs;
        bit          in_o, vis;
        int          hh, vv;
        logic [37:0] exp_now;
        @(negedge clk);
        hs = 1'($urandom); vs = 1'($urandom);
        hcount_in = p.h; vcount_in = p.v; hsync_in = hs; vsync_in = vs;
        hblnk_in = p.hb; vblnk_in = p.vb; rgb_in = p.rgb;
        hh = int'(p.h); vv = int'(p.v);
        in_o = (m_x != 0) && (hh >= m_x) && (hh < m_x + OBST_W) &&
               (((vv >= m_y1) && (vv < m_y1 + OBST_H)) || ((vv >= m_y2) && (vv < m_y2 + OBST_H)));
        vis  = !m_eg || ((((m_end_frames - 1) / BLINK_FRAMES) % 2) == 0);
        if (p.hb || p.vb)      want_rgb = p.rgb;
        else if (in_o && vis)  want_rgb = m_eg ? COLOR_END : COLOR_OK;
        else                   want_rgb = p.rgb;
        exp_now = {p.h, p.v, hs, vs, p.hb, p.vb, want_rgb};
        if (p.vb && !m_prev_vb) begin
            m_x  = int'(obstacle_xpos_1);
            m_y1 = int'(obstacle_ypos_1);
            m_y2 = int'(obstacle_ypos_2);
            m_eg = endgame;
            m_end_frames = endgame ? m_end_frames + 1 : 0;
        end
        m_prev_vb = p.vb;
        @(posedge clk);
        #1;
        got_v = obs_s; want_v = exp_prev; exp_prev = exp_now;
    endtask

    task automatic push_pix(input int h, input int v, input bit hb, input bit vb);
        pix_t p;
        p.h = 11'(h); p.v = 11'(v); p.hb = hb; p.vb = vb; p.rgb = 12'($urandom);
        pix_q.push_back(p);
    endtask

    task automatic add_vsync();
        for (int i = 0; i < 3; i++) push_pix(0, 600, 1'b1, 1'b1);
        push_pix(0, 0, 1'b1, 1'b0);
    endtask

    task automatic add_row(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) push_pix(h, v, 1'b0, 1'b0);
    endtask

    task automatic set_obst(input int x, input int y1, input int y2, input bit eg);
        obstacle_xpos_1 = 12'(x); obstacle_ypos_1 = 12'(y1);
        obstacle_ypos_2 = 12'(y2); endgame = eg;
    endtask

    task automatic test_reset();
        pix_t p;
        rst = 1'b1;
        p.h = 11'd0; p.v = 11'd0; p.hb = 1'b0; p.vb = 1'b0; p.rgb = 12'd0;
        hcount_in = 11'd5; vcount_in = 11'd7; hsync_in = 1'b1; vsync_in = 1'b1;
        hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = 12'hABC;
        set_obst(0, 0, 0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_s !== 38'd0) begin
            errors++; $display("FAIL reset got=%h want=%h", obs_s, 38'd0);
        end
        rst = 1'b0;
        step(p);
        checks++;
        if (got_v !== want_v) begin
            errors++; $display("FAIL reset_release got=%h want=%h", got_v, want_v);
        end
    endtask

    task automatic test_latency();
        pix_t p;
        set_obst(0, 250, 440, 1'b0);
        for (int i = 0; i < 300; i++) begin
            p.h = 11'($urandom); p.v = 11'($urandom);
            p.hb = 1'($urandom); p.vb = 1'($urandom); p.rgb = 12'($urandom);
            step(p);
            checks++;
            if (got_v !== want_v) begin
                errors++; $display("FAIL latency got=%h want=%h", got_v, want_v);
            end
        end
    endtask

    task automatic test_random();
        pix_t p;
        int   x, y, t, n;
        for (int f = 0; f < 6; f++) begin
            x = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 2000));
            set_obst(x, int'($urandom_range(0, 2000)), int'($urandom_range(0, 2000)), 1'b0);
            add_vsync();
            for (int i = 0; i < 250; i++) begin
                t = int'(obstacle_xpos_1) + int'($urandom_range(0, 60)) - 10;
                if (t < 0) t = 0;
                if (t > 2047) t = 2047;
                y = ($urandom_range(0, 1) == 0) ? int'(obstacle_ypos_1) : int'(obstacle_ypos_2);
                y = y + int'($urandom_range(0, 50)) - 10;
                if (y < 0) y = 0;
                if (y > 2047) y = 2047;
                push_pix(t, y, ($urandom_range(0, 9) == 0), 1'b0);
            end
            n = 0;
            while (pix_q.size() > 0) begin
                p = pix_q.pop_front();
                if (n == 150) set_obst(int'($urandom_range(0, 2000)), int'($urandom_range(0, 2000)),
                                       int'($urandom_range(0, 2000)), 1'b0);
                n++;
                step(p);
                checks++;
                if (got_v !== want_v) begin
                    errors++; $display("FAIL random got=%h want=%h", got_v, want_v);
                end
            end
        end
    endtask

    task automatic test_draw();
        pix_t p;
        int   rows[9] = '{249, 250, 265, 279, 280, 439, 440, 469, 470};
        set_obst(750, 250, 440, 1'b0);
        add_vsync();
        foreach (rows[i]) add_row(rows[i], 745, 795);
        for (int i = 0; i < 200; i++)
            push_pix(int'($urandom_range(700, 840)), int'($urandom_range(200, 500)), 1'b0, 1'b0);
        while (pix_q.size() > 0) begin
            p = pix_q.pop_front();
            step(p);
            checks++;
            if (got_v !== want_v) begin
                errors++; $display("FAIL draw got=%h want=%h", got_v, want_v);
            end
        end
    endtask

    task automatic test_frame_sync();
        pix_t p;
        bit   changed = 1'b0;
        set_obst(750, 250, 440, 1'b0);
        add_vsync();
        add_row(100, 690, 800);
        add_row(260, 690, 800);
        add_vsync();
        add_row(260, 690, 800);
        while (pix_q.size() > 0) begin
            p = pix_q.pop_front();
            if (p.v == 11'd100 && !changed) begin
                obstacle_xpos_1 = 12'd700;
                changed = 1'b1;
            end
            step(p);
            checks++;
            if (got_v !== want_v) begin
                errors++; $display("FAIL frame_sync got=%h want=%h", got_v, want_v);
            end
        end
    endtask

    task automatic test_blank_empty();
        pix_t p;
        set_obst(750, 250, 440, 1'b0);
        add_vsync();
        for (int h = 740; h <= 800; h++) push_pix(h, 260, (h >= 770), 1'b0);
        for (int step_i = 0; step_i < 2; step_i++) begin
            while (pix_q.size() > 0) begin
                p = pix_q.pop_front();
                step(p);
                checks++;
                if (got_v !== want_v) begin
                    errors++; $display("FAIL blank_empty got=%h want=%h", got_v, want_v);
                end
            end
            set_obst(0, 250, 440, 1'b0);
            add_vsync();
            add_row(260, 740, 800);
            add_row(445, 740, 800);
        end
    endtask

    task automatic test_endgame();
        pix_t p;
        set_obst(750, 250, 440, 1'b1);
        for (int f = 0; f < 50; f++) begin
            if (f == 49) endgame = 1'b0;
            add_vsync();
            add_row(260, 745, 760);
            add_row(445, 786, 792);
            while (pix_q.size() > 0) begin
                p = pix_q.pop_front();
                step(p);
                checks++;
                if (got_v !== want_v) begin
                    errors++; $display("FAIL endgame frame=%0d got=%h want=%h", f, got_v, want_v);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        pix_t p;
        bit   done = 1'b0;
        set_obst(750, 250, 440, 1'b0);
        add_vsync();
        add_row(299, 745, 760);
        add_row(300, 745, 760);
        add_row(445, 745, 760);
        add_vsync();
        add_row(445, 745, 760);
        push_pix(0, 0, 1'b1, 1'b0);
        push_pix(0, 0, 1'b1, 1'b0);
        while (pix_q.size() > 0) begin
            p = pix_q.pop_front();
            if (p.v == 11'd300 && p.h == 11'd750 && !done) begin
                done = 1'b1;
                rst = 1'b1;
                #1;
                checks++;
                if (obs_s !== 38'd0) begin
                    errors++; $display("FAIL async_reset got=%h want=%h", obs_s, 38'd0);
                end
                @(posedge clk);
                #1;
                checks++;
                if (obs_s !== 38'd0) begin
                    errors++; $display("FAIL async_reset_hold got=%h want=%h", obs_s, 38'd0);
                end
                rst = 1'b0;
                model_reset();
            end
            step(p);
            checks++;
            if (got_v !== want_v) begin
                errors++; $display("FAIL async_reset_after got=%h want=%h", got_v, want_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_random();
        test_draw();
        test_frame_sync();
        test_blank_empty();
        test_endgame();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
